// File: rtl/alu_reg_sequencer.sv
// rtl/alu_reg_sequencer.sv - operand fetch / write-back sequencer around an 8-bit combinational ALU
// Three-state sequencer (IDLE -> EXEC -> WB) with an 8-entry register file, R0 hardwired to zero.
module alu_reg_sequencer #(
  parameter int          DATA_W    = 8,
  parameter int          ADDR_W    = 3,
  parameter logic [3:0]  IDLE_CTRL = 4'b1111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_ctrl,
  input  logic [ADDR_W-1:0] in_rx,
  input  logic [ADDR_W-1:0] in_ry,
  input  logic [ADDR_W-1:0] in_rw,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              done_valid,
  output logic [DATA_W-1:0] done_data,
  output logic              done_carry,
  output logic              flag_c,
  input  logic [ADDR_W-1:0] dbg_rsel,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   rf_q [NREG];
  logic [3:0]          ctrl_q;
  logic [ADDR_W-1:0]   rx_q, ry_q, rw_q;
  logic                use_imm_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   res_q;
  logic                carry_q;
  logic                flag_q;
  logic [DATA_W-1:0]   rd_x, rd_y;
  logic                accept;
  logic                is_addsub;

  assign accept    = (state_q == S_IDLE) && in_valid;
  assign is_addsub = (ctrl_q == 4'b0000) || (ctrl_q == 4'b0001);

  // R0 reads as zero regardless of storage contents
  assign rd_x      = (rx_q == '0) ? '0 : rf_q[rx_q];
  assign rd_y      = (ry_q == '0) ? '0 : rf_q[ry_q];
  assign dbg_rdata = (dbg_rsel == '0) ? '0 : rf_q[dbg_rsel];

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    alu_ctrl = IDLE_CTRL;
    alu_x    = '0;
    alu_y    = '0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_ctrl = ctrl_q;
        alu_x    = rd_x;
        alu_y    = use_imm_q ? imm_q : rd_y;
        state_d  = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
      rw_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ctrl_q    <= in_ctrl;
        rx_q      <= in_rx;
        ry_q      <= in_ry;
        rw_q      <= in_rw;
        use_imm_q <= in_use_imm;
        imm_q     <= in_imm;
      end
      if (state_q == S_EXEC) begin
        res_q   <= alu_out;
        carry_q <= alu_carry;
      end
      if ((state_q == S_WB) && is_addsub) flag_q <= carry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if ((state_q == S_WB) && (rw_q != '0)) begin
      rf_q[rw_q] <= res_q;
    end
  end

  assign done_valid = (state_q == S_WB);
  assign done_data  = res_q;
  assign done_carry = carry_q;
  assign flag_c     = flag_q;

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// tb/tb_alu_reg_sequencer.sv - scoreboard bench for alu_reg_sequencer with an ALU model on the alu_* bus
// Directed cases followed by random commands; a negedge monitor checks done pulses and the ALU bus.
module tb_alu_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_ctrl;
  logic [2:0] in_rx, in_ry, in_rw;
  logic       in_use_imm;
  logic [7:0] in_imm;
  logic [3:0] alu_ctrl;
  logic [7:0] alu_x, alu_y, alu_out;
  logic       alu_carry;
  logic       done_valid;
  logic [7:0] done_data;
  logic       done_carry;
  logic       flag_c;
  logic [2:0] dbg_rsel;
  logic [7:0] dbg_rdata;

  always #5 clk = ~clk;

  alu_reg_sequencer #(.DATA_W(8), .ADDR_W(3), .IDLE_CTRL(4'b1111)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_rx(in_rx), .in_ry(in_ry), .in_rw(in_rw),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .done_valid(done_valid), .done_data(done_data), .done_carry(done_carry),
    .flag_c(flag_c), .dbg_rsel(dbg_rsel), .dbg_rdata(dbg_rdata)
  );

  // ALU model: {carry, out}; codes 1101-1111 return zero with no carry
  function automatic logic [8:0] alu_f(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
    logic [8:0] r;
    r = '0;
    case (c)
      4'd0:  r = {1'b0, x} + {1'b0, y};
      4'd1:  r = {x < y, x - y};
      4'd2:  r = {1'b0, x & y};
      4'd3:  r = {1'b0, x | y};
      4'd4:  r = {1'b0, x ^ y};
      4'd5:  r = {1'b0, ~x};
      4'd6:  r = {x[7], x << 1};
      4'd7:  r = {x[0], x >> 1};
      4'd8:  r = {1'b0, x} + 9'd1;
      4'd9:  r = {x == 8'd0, x - 8'd1};
      4'd10: r = {1'b0, y};
      4'd11: r = {8'd0, x < y};
      4'd12: r = {8'd0, x == y};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb {alu_carry, alu_out} = alu_f(alu_ctrl, alu_x, alu_y);

  typedef struct {
    logic [7:0] data;
    logic       c;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] m_rf [8];
  logic       m_flag;
  int         exec_cyc = -100;
  logic [3:0] exp_ctrl;
  logic [7:0] exp_x, exp_y;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cyc == exec_cyc)
        chk("alu_bus_exec", {alu_ctrl, alu_x, alu_y}, {exp_ctrl, exp_x, exp_y});
      else
        chk("alu_bus_idle", {alu_ctrl, alu_x, alu_y}, {4'b1111, 16'h0000});
      if (done_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done_data %0h expected no pulse", done_data);
        end else begin
          mon_e = sb_q.pop_front();
          chk("done_data", done_data, mon_e.data);
          chk("done_carry", done_carry, mon_e.c);
          chk("done_latency", cyc, mon_e.cyc);
        end
      end
    end
  end

  // Caller is positioned just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [3:0] c, input logic [2:0] rx, input logic [2:0] ry,
                       input logic [2:0] rw, input logic ui, input logic [7:0] imm, input int stall);
    int n;
    exp_t e;
    logic [7:0] x, y;
    logic [8:0] r;
    in_valid = 1'b1; in_ctrl = c; in_rx = rx; in_ry = ry; in_rw = rw;
    in_use_imm = ui; in_imm = imm;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 20 cycles");
    end else begin
      if (stall >= 0) chk("ready_low_cycles", n, stall);
      x = m_rf[rx];
      y = ui ? imm : m_rf[ry];
      r = alu_f(c, x, y);
      e.data = r[7:0];
      e.c    = r[8];
      e.cyc  = cyc + 2;
      sb_q.push_back(e);
      exec_cyc = cyc + 1;
      exp_ctrl = c; exp_x = x; exp_y = y;
      if (rw != 3'd0) m_rf[rw] = r[7:0];
      if (c == 4'd0 || c == 4'd1) m_flag = r[8];
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    idle(4);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      dbg_rsel = 3'(i);
      #1;
      chk({tag, "_reg"}, dbg_rdata, m_rf[i]);
    end
    chk({tag, "_flag_c"}, flag_c, m_flag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0; in_ctrl = '0; in_rx = '0; in_ry = '0; in_rw = '0;
    in_use_imm = 1'b0; in_imm = '0; dbg_rsel = '0;
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    m_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done_valid", done_valid, 1'b0);
    chk("rst_done_data", done_data, 8'h00);
    chk("rst_done_carry", done_carry, 1'b0);
    chk("rst_flag_c", flag_c, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_alu_bus", {alu_ctrl, alu_x, alu_y}, {4'b1111, 16'h0000});
    rst = 1'b0;
    @(posedge clk); #1;
    check_state("reset");

    issue(4'd0, 3'd0, 3'd0, 3'd1, 1'b1, 8'h5A, 0);
    check_state("imm_load");

    issue(4'd0, 3'd1, 3'd0, 3'd2, 1'b1, 8'hA6, 0);
    issue(4'd2, 3'd1, 3'd0, 3'd3, 1'b1, 8'h0F, 2);
    check_state("carry_and");

    issue(4'd0, 3'd0, 3'd0, 3'd4, 1'b1, 8'h03, 0);
    issue(4'd0, 3'd0, 3'd0, 3'd5, 1'b1, 8'h05, 2);
    issue(4'd1, 3'd4, 3'd5, 3'd6, 1'b0, 8'hC3, 2);
    check_state("sub_borrow");

    issue(4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 8'h11, 0);
    issue(4'd12, 3'd0, 3'd0, 3'd7, 1'b0, 8'h00, 2);
    check_state("r0_b2b");

    issue(4'd13, 3'd1, 3'd2, 3'd3, 1'b0, 8'h00, 0);
    issue(4'd0, 3'd3, 3'd3, 3'd3, 1'b0, 8'h00, 2);
    check_state("undef_hazard");

    in_valid = 1'b1; in_ctrl = 4'd0; in_rx = 3'd0; in_ry = 3'd0; in_rw = 3'd1;
    in_use_imm = 1'b1; in_imm = 8'h77;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    exec_cyc = -100;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    m_flag = 1'b0;
    dbg_rsel = 3'd1;
    #1;
    chk("midrst_done_valid", done_valid, 1'b0);
    chk("midrst_done_data", done_data, 8'h00);
    chk("midrst_alu_bus", {alu_ctrl, alu_x, alu_y}, {4'b1111, 16'h0000});
    chk("midrst_r1", dbg_rdata, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    check_state("mid_reset");

    for (int k = 0; k < 60; k++) begin
      issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), -1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    check_state("random");

    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      n++;
      @(posedge clk);
    end
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_reg_sequencer.md
Name: alu_reg_sequencer

Overview:
Operand-fetch and write-back stage wrapped around the 8-bit combinational ALU (ctrl/x/y -> out/carry).
- Holds an 8-entry register file and accepts one command at a time over a valid/ready handshake.
- Drives the ALU's ctrl, x and y inputs, captures out/carry, and writes the result back.
- Reports each completion with a one-cycle done pulse and keeps a sticky carry flag.

Parameters:
DATA_W, 8, data width of registers and ALU operands
ADDR_W, 3, register address width (2**ADDR_W registers)
IDLE_CTRL, 4'b1111, ALU ctrl code driven when no command executes (ALU returns 0)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  command present
in_ready  output  1  block can accept a command
in_ctrl  input  4  ALU opcode (0000 ADD … 1100 EQ)
in_rx  input  ADDR_W  source register for x
in_ry  input  ADDR_W  source register for y
in_rw  input  ADDR_W  destination register
in_use_imm  input  1  1: y = in_imm; 0: y = R[in_ry]
in_imm  input  DATA_W  immediate operand
alu_ctrl  output  4  to ALU ctrl
alu_x  output  DATA_W  to ALU x
alu_y  output  DATA_W  to ALU y
alu_out  input  DATA_W  from ALU out
alu_carry  input  1  from ALU carry
done_valid  output  1  one-cycle completion pulse
done_data  output  DATA_W  result of completed command
done_carry  output  1  ALU carry of completed command
flag_c  output  1  carry of last ADD/SUB
dbg_rsel  input  ADDR_W  debug read address
dbg_rdata  output  DATA_W  combinational R[dbg_rsel]

Behaviour:
- Reset (async, rst=1) sets:
  - R0..R7 = 0, flag_c = 0, state = IDLE.
  - done_valid = 0, done_data = 0, done_carry = 0.
  - Latched command fields = 0.
- R0 reads as 0 always. Writes to R0 are discarded; done_valid still pulses.
- FSM has three states, IDLE -> EXEC -> WB -> IDLE. Edge names: T0 = accept edge; T1 = next edge; T2 = the one after.
- IDLE:
  - in_ready = 1.
  - At an edge with in_valid=1, latch ctrl/rx/ry/rw/use_imm/imm and go to EXEC (this edge is T0).
  - With in_valid=0, stay in IDLE.
- EXEC (cycle T0–T1):
  - in_ready = 0, alu_ctrl = latched ctrl.
  - alu_x = R[rx]; alu_y = use_imm ? imm : R[ry].
  - At T1, capture alu_out and alu_carry into the result registers, go to WB.
- WB (cycle T1–T2):
  - in_ready = 0, done_valid = 1, done_data and done_carry = captured values.
  - At T2:
    - R[rw] <= result (if rw != 0).
    - flag_c <= carry only if ctrl is 0000 or 0001; otherwise flag_c holds.
    - Go to IDLE.
- Outside EXEC: alu_ctrl = IDLE_CTRL, alu_x = 0, alu_y = 0.
- Latency:
  - done_valid is asserted in the 2nd cycle after the accept edge.
  - in_ready returns 1 after T2.
  - Throughput is one command per 3 cycles with in_valid held high.
- done_data/done_carry hold their last values after the pulse, until the next capture.
- in_valid while busy: no effect. The command must be held by the source until in_ready=1.
- Hazards: write-back completes before the next EXEC reads, so rx/ry = previous rw reads the new value. No forwarding is required.
- Undefined opcodes (1101–1111) pass through to the ALU. The ALU result (0) is written back with carry 0. flag_c is unchanged.
- rx == ry == rw is legal; operands are read in EXEC and the write happens at T2.
- Reset mid-operation (EXEC or WB) aborts the command:
  - No register write, no done pulse.
  - Everything returns to reset values immediately.
- dbg_rdata is purely combinational and reflects writes after T2.

Test Plan:
- Immediate load: after reset, cmd {ADD, rx=0, use_imm=1, imm=8'h5A, rw=1}.
  - done_valid exactly 2 cycles after accept, done_data=8'h5A, done_carry=0.
  - dbg R1 = 8'h5A, flag_c = 0.
- Carry out: cmd {ADD, rx=1, imm=8'hA6, rw=2} with R1=5A.
  - done_data=8'h00, done_carry=1, R2=00, flag_c=1.
  - Follow with {BITAND, rx=1, imm=8'h0F, rw=3} -> R3=8'h0A, flag_c stays 1.
- Subtract/borrow: R4=03 and R5=05, then {SUB, rx=4, ry=5, use_imm=0, rw=6}.
  - R6=8'hFE, carry=1, flag_c=1.
- R0 write and back-to-back: in_valid held high with two commands: {ADD, imm=8'h11, rw=0}, then {EQ, rx=0, ry=0, rw=7}.
  - in_ready low for 2 cycles after each accept.
  - done pulses 3 cycles apart.
  - R0 stays 0; R7 = 8'h01.
- Busy stall: assert in_valid during EXEC with different fields.
  - Not accepted until IDLE.
  - alu_ctrl = 4'b1111 and alu_x = alu_y = 0 in IDLE/WB cycles.
- Reset mid-op: assert rst asynchronously (between edges) during EXEC of {ADD, imm=8'h77, rw=1}.
  - Outputs go to 0 immediately, no done pulse.
  - R1 = 0, in_ready = 1 after rst deasserts.
